// File: rtl/stream_packetizer.sv
// ADC stream packetizer: slices an AXI-Stream sample flow into LENGTH-beat packets for a DMA S2MM port,
// with a 2-entry output skid FIFO and an AXI4-Lite control/status register file.
module stream_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic [2:0]            s_axi_lite_awprot,
  input  logic                  s_axi_lite_awvalid,
  output logic                  s_axi_lite_awready,
  input  logic [31:0]           s_axi_lite_wdata,
  input  logic [3:0]            s_axi_lite_wstrb,
  input  logic                  s_axi_lite_wvalid,
  output logic                  s_axi_lite_wready,
  output logic [1:0]            s_axi_lite_bresp,
  output logic                  s_axi_lite_bvalid,
  input  logic                  s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic [2:0]            s_axi_lite_arprot,
  input  logic                  s_axi_lite_arvalid,
  output logic                  s_axi_lite_arready,
  output logic [31:0]           s_axi_lite_rdata,
  output logic [1:0]            s_axi_lite_rresp,
  output logic                  s_axi_lite_rvalid,
  input  logic                  s_axi_lite_rready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LENGTH = 3'd1;
  localparam logic [2:0] REG_TARGET = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_BEATS  = 3'd4;
  localparam logic [2:0] REG_PKTS   = 3'd5;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                state_q, state_d;
  logic                  start_run;
  logic [1:0]            ctrl_q;
  logic [CNT_WIDTH-1:0]  length_q, pkt_target_q, beat_cnt_q, pkt_cnt_q;
  logic                  enable, oneshot;
  logic                  accept, tag, last_accept, target_hit, pop;
  logic [CNT_WIDTH-1:0]  target_eff;

  logic [DATA_WIDTH-1:0] skid_data [2];
  logic                  skid_last [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            skid_cnt;

  logic                  ready_en_q;
  logic                  aw_full_q, w_full_q;
  logic [ADDR_WIDTH-3:0] aw_word_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  do_write, wr_err, rd_err;
  logic [2:0]            wr_idx, rd_idx;
  logic [31:0]           wr_old, wr_merged, rd_word;
  logic                  unused_ok;

  // Only word offsets 0x00-0x14 with all upper address bits clear are mapped; 7 marks unmapped.
  function automatic logic [2:0] reg_index(input logic [ADDR_WIDTH-3:0] word);
    logic [2:0] idx;
    idx = 3'd7;
    if (word[ADDR_WIDTH-3:4] == '0 && word[3:0] < 4'd6) idx = word[2:0];
    return idx;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val, input logic [31:0] new_val,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  function automatic logic [31:0] zext(input logic [CNT_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_WIDTH-1:0] = v;
    return r;
  endfunction

  assign enable      = ctrl_q[0];
  assign oneshot     = ctrl_q[1];
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign target_eff  = (pkt_target_q == '0) ? CNT_ONE : pkt_target_q;
  assign tag         = (beat_cnt_q == length_q - CNT_ONE);
  assign accept      = s_axis_tvalid & s_axis_tready;
  assign last_accept = accept & tag;
  assign target_hit  = (pkt_cnt_q >= target_eff - CNT_ONE);
  assign pop         = m_axis_tvalid & m_axis_tready;

  // Once enable drops at a packet boundary no new packet may start, so input is closed there too.
  assign s_axis_tready = (state_q == RUN) & (skid_cnt != 2'd2) & (enable | (beat_cnt_q != '0));

  assign m_axis_tvalid = (skid_cnt != 2'd0);
  assign m_axis_tdata  = skid_data[rd_ptr];
  assign m_axis_tlast  = skid_last[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    case (state_q)
      IDLE: if (enable && length_q != '0) begin
        state_d   = RUN;
        start_run = 1'b1;
      end
      RUN: begin
        if (oneshot && last_accept && target_hit)                state_d = DONE;
        else if (!enable && (beat_cnt_q == '0 || last_accept))   state_d = IDLE;
      end
      DONE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (start_run) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (accept) begin
      beat_cnt_q <= tag ? '0 : beat_cnt_q + CNT_ONE;
      if (tag && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
    end
  end

  // The tlast tag travels with its beat, so the output side never needs the counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      skid_data[0] <= '0;
      skid_data[1] <= '0;
      skid_last[0] <= 1'b0;
      skid_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      skid_cnt     <= 2'd0;
    end else begin
      if (accept) begin
        skid_data[wr_ptr] <= s_axis_tdata;
        skid_last[wr_ptr] <= tag;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  assign s_axi_lite_awready = ready_en_q & ~aw_full_q & ~s_axi_lite_bvalid;
  assign s_axi_lite_wready  = ready_en_q & ~w_full_q & ~s_axi_lite_bvalid;
  assign s_axi_lite_arready = ready_en_q & ~s_axi_lite_rvalid;
  assign do_write           = aw_full_q & w_full_q & ~s_axi_lite_bvalid;

  always_comb begin
    wr_idx = reg_index(aw_word_q);
    wr_err = 1'b1;
    wr_old = '0;
    case (wr_idx)
      REG_CTRL:   begin wr_err = 1'b0; wr_old = {30'd0, ctrl_q}; end
      REG_LENGTH: begin wr_err = busy; wr_old = zext(length_q); end
      REG_TARGET: begin wr_err = busy; wr_old = zext(pkt_target_q); end
      default:    wr_err = 1'b1;
    endcase
    wr_merged = apply_strb(wr_old, w_data_q, w_strb_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_q       <= 2'd0;
      length_q     <= '0;
      pkt_target_q <= CNT_ONE;
    end else if (do_write && !wr_err) begin
      case (wr_idx)
        REG_CTRL:   ctrl_q       <= wr_merged[1:0];
        REG_LENGTH: length_q     <= wr_merged[CNT_WIDTH-1:0];
        REG_TARGET: pkt_target_q <= wr_merged[CNT_WIDTH-1:0];
        default:    ctrl_q       <= ctrl_q;
      endcase
    end
  end

  // AW and W are parked independently; the register update and BVALID follow once both are held.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q        <= 1'b0;
      aw_full_q         <= 1'b0;
      aw_word_q         <= '0;
      w_full_q          <= 1'b0;
      w_data_q          <= '0;
      w_strb_q          <= '0;
      s_axi_lite_bvalid <= 1'b0;
      s_axi_lite_bresp  <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      if (s_axi_lite_awvalid && s_axi_lite_awready) begin
        aw_full_q <= 1'b1;
        aw_word_q <= s_axi_lite_awaddr[ADDR_WIDTH-1:2];
      end
      if (s_axi_lite_wvalid && s_axi_lite_wready) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi_lite_wdata;
        w_strb_q <= s_axi_lite_wstrb;
      end
      if (do_write) begin
        aw_full_q         <= 1'b0;
        w_full_q          <= 1'b0;
        s_axi_lite_bvalid <= 1'b1;
        s_axi_lite_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_lite_bvalid && s_axi_lite_bready) begin
        s_axi_lite_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_idx  = reg_index(s_axi_lite_araddr[ADDR_WIDTH-1:2]);
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      REG_CTRL:   rd_word = {30'd0, ctrl_q};
      REG_LENGTH: rd_word = zext(length_q);
      REG_TARGET: rd_word = zext(pkt_target_q);
      REG_STATUS: rd_word = {30'd0, done, busy};
      REG_BEATS:  rd_word = zext(beat_cnt_q);
      REG_PKTS:   rd_word = zext(pkt_cnt_q);
      default:    rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_lite_rvalid <= 1'b0;
      s_axi_lite_rdata  <= '0;
      s_axi_lite_rresp  <= RESP_OKAY;
    end else if (s_axi_lite_arvalid && s_axi_lite_arready) begin
      s_axi_lite_rvalid <= 1'b1;
      s_axi_lite_rdata  <= rd_word;
      s_axi_lite_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_lite_rvalid && s_axi_lite_rready) begin
      s_axi_lite_rvalid <= 1'b0;
    end
  end

  assign unused_ok = &{1'b0, s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0],
                       s_axi_lite_awprot, s_axi_lite_arprot};

endmodule

// File: tb/tb_stream_packetizer.sv
// Randomized scoreboard bench for stream_packetizer: a packet-index model predicts every output beat,
// while directed register sequences exercise one-shot, clean stop, protection errors and reset.
module tb_stream_packetizer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        aclk, aresetn;
  logic [31:0] s_axis_tdata, m_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        busy, done;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];
  int    model_len = 1;
  int    model_epoch = 0;
  int    seen_epoch = 0;
  int    model_beats = 0;
  bit    rand_ready = 1'b0;
  bit    fixed_ready = 1'b1;
  logic  stalled = 1'b0;
  logic [31:0] held_data;
  logic  held_last;

  stream_packetizer #(.DATA_WIDTH(32), .CNT_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awprot(3'b000), .s_axi_lite_awvalid(awvalid),
    .s_axi_lite_awready(awready), .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb),
    .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp),
    .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr),
    .s_axi_lite_arprot(3'b000), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_axis_tready = rand_ready ? ($urandom_range(1) == 1) : fixed_ready;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired or event not expected", name);
  endtask

  // Reference model: beat n of a run (counting from 0) closes a packet when n mod LENGTH == LENGTH-1.
  always @(negedge aclk) begin
    if (!aresetn) exp_q.delete();
    else if (s_axis_tvalid && s_axis_tready) begin
      if (seen_epoch != model_epoch) begin
        seen_epoch  = model_epoch;
        model_beats = 0;
      end
      exp_q.push_back('{data: s_axis_tdata, last: (model_beats % model_len) == model_len - 1});
      model_beats++;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) stalled = 1'b0;
    else begin
      if (stalled) begin
        checkOutput("hold_valid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("hold_data", m_axis_tdata, held_data);
        checkOutput("hold_last", 32'(m_axis_tlast), 32'(held_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) failNow("unexpected_beat");
        else begin
          beat_t e;
          e = exp_q.pop_front();
          checkOutput("beat_data", m_axis_tdata, e.data);
          checkOutput("beat_last", 32'(m_axis_tlast), 32'(e.last));
        end
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      held_last = m_axis_tlast;
    end
  end

  task automatic start_model(input int len);
    model_len = len;
    model_epoch++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic writeReg(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input string name);
    bit got = 0;
    bit aw_hs, w_hs;
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge aclk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (bvalid) begin
        got = 1;
        checkOutput(name, 32'(bresp), 32'(exp_resp));
      end
      @(posedge aclk);
      #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    if (!got) failNow({name, "_timeout"});
  endtask

  task automatic readReg(input logic [11:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input string name);
    bit got = 0;
    bit ar_hs;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge aclk);
      ar_hs = arvalid && arready;
      if (rvalid) begin
        got = 1;
        checkOutput(name, rdata, exp_data);
        checkOutput({name, "_resp"}, 32'(rresp), 32'(exp_resp));
      end
      @(posedge aclk);
      #1;
      if (ar_hs) arvalid = 1'b0;
    end
    arvalid = 1'b0; rready = 1'b0;
    if (!got) failNow({name, "_timeout"});
  endtask

  // Offers up to n beats with the given valid probability, holding data while a beat is refused.
  task automatic applyStimulus(input int n, input int pct, input int max_cycles, output int sent,
                               output int cycles);
    bit pending = 0;
    sent = 0;
    cycles = 0;
    while (sent < n && cycles < max_cycles) begin
      if (!pending) begin
        s_axis_tvalid = ($urandom_range(99) < pct);
        s_axis_tdata  = $urandom;
      end
      @(negedge aclk);
      if (s_axis_tvalid && s_axis_tready) begin
        sent++;
        pending = 0;
      end else pending = s_axis_tvalid;
      @(posedge aclk);
      #1;
      cycles++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && (exp_q.size() != 0 || m_axis_tvalid); n++) tick(1);
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sent, cycles;
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    tick(3);
    @(negedge aclk);
    checkOutput("reset_flags", 32'({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done,
                awready, wready, arready, bvalid, rvalid}), 32'd0);
    checkOutput("reset_tdata", m_axis_tdata, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    tick(2);
    readReg(12'h000, 32'd0, 2'b00, "rst_ctrl");
    readReg(12'h004, 32'd0, 2'b00, "rst_length");
    readReg(12'h008, 32'd1, 2'b00, "rst_target");
    readReg(12'h00C, 32'd0, 2'b00, "rst_status");

    $display("[TB] enable with LENGTH=0 must stay idle");
    writeReg(12'h000, 32'd1, 4'hF, 2'b00, "wr_ctrl_len0");
    tick(3);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    writeReg(12'h000, 32'd0, 4'hF, 2'b00, "wr_ctrl_off");

    $display("[TB] continuous, LENGTH=4, 12 beats");
    start_model(4);
    writeReg(12'h004, 32'd4, 4'hF, 2'b00, "wr_len4");
    writeReg(12'h000, 32'd1, 4'hF, 2'b00, "wr_ctrl_run");
    tick(3);
    applyStimulus(12, 100, 100, sent, cycles);
    checkOutput("t1_sent", 32'(sent), 32'd12);
    checkOutput("t1_cycles", 32'(cycles), 32'd12);
    wait_drain();
    readReg(12'h014, 32'd3, 2'b00, "t1_pkt_cnt");
    readReg(12'h010, 32'd0, 2'b00, "t1_beat_cnt");
    writeReg(12'h000, 32'd0, 4'hF, 2'b00, "t1_stop");
    tick(2);
    checkOutput("t1_busy_off", 32'(busy), 32'd0);

    $display("[TB] one-shot, LENGTH=3, PKT_TARGET=2");
    start_model(3);
    writeReg(12'h004, 32'd3, 4'hF, 2'b00, "wr_len3");
    writeReg(12'h008, 32'd2, 4'hF, 2'b00, "wr_target2");
    writeReg(12'h000, 32'd3, 4'hF, 2'b00, "wr_ctrl_oneshot");
    tick(3);
    applyStimulus(10, 100, 30, sent, cycles);
    checkOutput("t2_sent", 32'(sent), 32'd6);
    wait_drain();
    @(negedge aclk);
    checkOutput("t2_done_busy_tready", 32'({done, busy, s_axis_tready}), 32'b100);
    @(posedge aclk); #1;
    readReg(12'h00C, 32'd2, 2'b00, "t2_status");
    readReg(12'h014, 32'd2, 2'b00, "t2_pkt_cnt");
    writeReg(12'h000, 32'd0, 4'hF, 2'b00, "t2_clear");
    tick(2);
    checkOutput("t2_done_off", 32'({done, busy}), 32'd0);

    $display("[TB] one-shot with PKT_TARGET=0, LENGTH=2");
    start_model(2);
    writeReg(12'h004, 32'd2, 4'hF, 2'b00, "wr_len2");
    writeReg(12'h008, 32'd0, 4'hF, 2'b00, "wr_target0");
    writeReg(12'h000, 32'd3, 4'hF, 2'b00, "wr_ctrl_oneshot0");
    tick(3);
    applyStimulus(10, 100, 30, sent, cycles);
    checkOutput("t2b_sent", 32'(sent), 32'd2);
    wait_drain();
    checkOutput("t2b_done", 32'(done), 32'd1);
    writeReg(12'h000, 32'd0, 4'hF, 2'b00, "t2b_clear");

    $display("[TB] clean stop mid-packet, LENGTH=5");
    start_model(5);
    writeReg(12'h004, 32'd5, 4'hF, 2'b00, "wr_len5");
    writeReg(12'h000, 32'd1, 4'hF, 2'b00, "t3_run");
    tick(3);
    applyStimulus(2, 100, 20, sent, cycles);
    checkOutput("t3_first", 32'(sent), 32'd2);
    writeReg(12'h000, 32'd0, 4'hF, 2'b00, "t3_stop");
    applyStimulus(10, 100, 30, sent, cycles);
    checkOutput("t3_tail", 32'(sent), 32'd3);
    wait_drain();
    checkOutput("t3_tready_busy", 32'({s_axis_tready, busy}), 32'd0);

    $display("[TB] random backpressure, LENGTH=7, 1001 beats");
    start_model(7);
    writeReg(12'h004, 32'd7, 4'hF, 2'b00, "wr_len7");
    writeReg(12'h000, 32'd1, 4'hF, 2'b00, "t4_run");
    tick(3);
    rand_ready = 1'b1;
    applyStimulus(1001, 70, 20000, sent, cycles);
    checkOutput("t4_sent", 32'(sent), 32'd1001);
    writeReg(12'h000, 32'd0, 4'hF, 2'b00, "t4_stop");
    rand_ready = 1'b0;
    wait_drain();
    readReg(12'h014, 32'd143, 2'b00, "t4_pkt_cnt");

    $display("[TB] register protection and error responses");
    writeReg(12'h004, 32'd4, 4'hF, 2'b00, "wr_len4b");
    writeReg(12'h000, 32'd1, 4'hF, 2'b00, "t5_run");
    tick(3);
    writeReg(12'h004, 32'd9, 4'hF, 2'b10, "t5_len_busy_resp");
    writeReg(12'h008, 32'd5, 4'hF, 2'b10, "t5_target_busy_resp");
    readReg(12'h004, 32'd4, 2'b00, "t5_len_kept");
    readReg(12'h03C, 32'd0, 2'b10, "t5_unmapped");
    writeReg(12'h00C, 32'd3, 4'hF, 2'b10, "t5_ro_resp");
    writeReg(12'h000, 32'd0, 4'hF, 2'b00, "t5_stop");
    tick(3);
    writeReg(12'h004, 32'h11223344, 4'b0010, 2'b00, "t5_strb_wr");
    readReg(12'h004, 32'h00003304, 2'b00, "t5_strb_rd");

    $display("[TB] reset in the middle of a packet");
    start_model(4);
    writeReg(12'h004, 32'd4, 4'hF, 2'b00, "wr_len4c");
    fixed_ready = 1'b0;
    writeReg(12'h000, 32'd1, 4'hF, 2'b00, "t6_run");
    tick(3);
    applyStimulus(2, 100, 20, sent, cycles);
    checkOutput("t6_pre", 32'(sent), 32'd2);
    aresetn = 1'b0;
    #2;
    checkOutput("t6_flags", 32'({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done}), 32'd0);
    checkOutput("t6_tdata", m_axis_tdata, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    fixed_ready = 1'b1;
    tick(2);
    readReg(12'h004, 32'd0, 2'b00, "t6_len_reset");
    readReg(12'h010, 32'd0, 2'b00, "t6_beat_reset");
    start_model(4);
    writeReg(12'h004, 32'd4, 4'hF, 2'b00, "wr_len4d");
    writeReg(12'h000, 32'd1, 4'hF, 2'b00, "t6_rerun");
    tick(3);
    applyStimulus(4, 100, 20, sent, cycles);
    checkOutput("t6_post", 32'(sent), 32'd4);
    wait_drain();
    readReg(12'h014, 32'd1, 2'b00, "t6_pkt_cnt");

    tick(5);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
